// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers and a registered busy flag.
// Define MDU_DIV_EN to build the divider; without it div/divu behave as no-ops.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDU_Rsel,
    output logic        busy,
    output logic [31:0] MDUout
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntBits   = $clog2(MaxCycles + 1);
    localparam int unsigned CntW      = (CntBits < 4) ? 4 : CntBits;

    localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
`ifdef MDU_DIV_EN
    localparam logic [CntW-1:0] DivCnt = CntW'(DIV_CYCLES);
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
`endif
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'b0, A} * {32'b0, B};

`ifdef MDU_DIV_EN
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] div_b;
    logic [31:0] quo_s, rem_s;
    logic [31:0] quo_u, rem_u;

    assign div_zero = (B == 32'd0);
    assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    // Dividing by 1 yields the required overflow result (LO=A, HI=0) and keeps /0 out of the datapath.
    assign div_b    = (div_zero || div_ovf) ? 32'd1 : B;

    assign quo_s = $unsigned($signed(A) / $signed(div_b));
    assign rem_s = $unsigned($signed(A) % $signed(div_b));
    assign quo_u = A / div_b;
    assign rem_u = A % div_b;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (MDUop)
                        OpMult: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MultCnt;
                            state_d   = StRun;
                        end
                        OpMultu: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MultCnt;
                            state_d   = StRun;
                        end
`ifdef MDU_DIV_EN
                        OpDiv: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quo_s;
                            pend_wr_d = !div_zero;
                            cnt_d     = DivCnt;
                            state_d   = StRun;
                        end
                        OpDivu: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quo_u;
                            pend_wr_d = !div_zero;
                            cnt_d     = DivCnt;
                            state_d   = StRun;
                        end
`endif
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // start is ignored here; the controller stalls on busy.
                if (cnt_q <= CntOne) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign MDUout = MDU_Rsel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed table, corner sequences and randomized ops
// against a behavioural model; expectations follow whether MDU_DIV_EN is defined.
module tb_mdu_unit;

    localparam int MultN = 5;
    localparam int DivN  = 10;
`ifdef MDU_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MDUop;
    logic [31:0] A;
    logic [31:0] B;
    logic        MDU_Rsel;
    logic        busy;
    logic [31:0] MDUout;

    int errors = 0;
    int checks = 0;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mdu_unit #(
        .MULT_CYCLES(MultN),
        .DIV_CYCLES (DivN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .MDUop   (MDUop),
        .A       (A),
        .B       (B),
        .MDU_Rsel(MDU_Rsel),
        .busy    (busy),
        .MDUout  (MDUout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          nb;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        MDU_Rsel = 1'b0;
        #1 lo = MDUout;
        MDU_Rsel = 1'b1;
        #1 hi = MDUout;
        MDU_Rsel = 1'b0;
    endtask

    task automatic check_hilo(input string name, input logic [31:0] hi_e, input logic [31:0] lo_e);
        logic [31:0] h, l;
        read_hilo(h, l);
        check({name, " HI"}, h, hi_e);
        check({name, " LO"}, l, lo_e);
    endtask

    // Reference: architectural result of one op from the current HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi_in, input logic [31:0] lo_in,
                         output logic [31:0] hi_o, output logic [31:0] lo_o, output int nb);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        hi_o = hi_in;
        lo_o = lo_in;
        nb = 0;
        case (op)
            3'd1: begin
                p = longint'(sa * sb);
                hi_o = p[63:32]; lo_o = p[31:0]; nb = MultN;
            end
            3'd2: begin
                p = ua * ub;
                hi_o = p[63:32]; lo_o = p[31:0]; nb = MultN;
            end
            3'd3: if (DivEn) begin
                nb = DivN;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    hi_o = r[31:0]; lo_o = q[31:0];
                end
            end
            3'd4: if (DivEn) begin
                nb = DivN;
                if (b != 0) begin
                    p = ua / ub; hi_o = 32'(ua % ub); lo_o = p[31:0];
                end
            end
            3'd5: hi_o = a;
            3'd6: lo_o = a;
            default: ;
        endcase
    endtask

    // Launch one op, count busy cycles, confirm pending values stay hidden, then check HI/LO.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e,
                         input int nb_e);
        logic [31:0] h, l;
        int n;
        bit leak;
        n = 0;
        leak = 1'b0;
        start = 1'b1; MDUop = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; MDUop = 3'd0;
        while (busy && n < 64) begin
            n++;
            read_hilo(h, l);
            if (h !== hi_m || l !== lo_m) leak = 1'b1;
            @(posedge clk); #1;
        end
        check({name, " busy cycles"}, n, nb_e);
        if (nb_e > 0) check({name, " hidden while busy"}, 32'(leak), 32'd0);
        check_hilo(name, hi_e, lo_e);
        hi_m = hi_e;
        lo_m = lo_e;
    endtask

    initial begin
        logic [31:0] eh, el, ra, rb;
        logic [2:0]  rop;
        int          enb, n;

        vecs[0] = '{3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, MultN};
        vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MultN};
        vecs[2] = '{3'd5, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 32'h0000_0001, 0};
        vecs[3] = '{3'd6, 32'h0000_1234, 32'd9,        32'hDEAD_BEEF, 32'h0000_1234, 0};
        vecs[4] = '{3'd0, 32'h5555_5555, 32'd1,        32'hDEAD_BEEF, 32'h0000_1234, 0};
        vecs[5] = '{3'd7, 32'h6666_6666, 32'd1,        32'hDEAD_BEEF, 32'h0000_1234, 0};
        vecs[6] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MultN};
        vecs[7] = '{3'd1, 32'd3,         32'd4,        32'h0000_0000, 32'h0000_000C, MultN};

        reset = 1'b0; start = 1'b0; MDUop = 3'd0; A = '0; B = '0; MDU_Rsel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        hi_m = '0; lo_m = '0;
        check("reset busy", 32'(busy), 32'd0);
        check_hilo("reset", 32'd0, 32'd0);

        for (int i = 0; i < 8; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].nb);
        end

        issue("divu 7/2", 3'd4, 32'd7, 32'd2,
              DivEn ? 32'd1 : hi_m, DivEn ? 32'd3 : lo_m, DivEn ? DivN : 0);
        issue("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2,
              DivEn ? 32'hFFFF_FFFF : hi_m, DivEn ? 32'hFFFF_FFFD : lo_m, DivEn ? DivN : 0);
        issue("mtlo pre-div0", 3'd6, 32'h0000_1234, 32'd0, hi_m, 32'h0000_1234, 0);
        issue("div by zero", 3'd3, 32'd77, 32'd0, hi_m, 32'h0000_1234, DivEn ? DivN : 0);
        issue("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF,
              DivEn ? 32'd0 : hi_m, DivEn ? 32'h8000_0000 : lo_m, DivEn ? DivN : 0);

        // mtlo pulsed during a running mult must be dropped.
        start = 1'b1; MDUop = 3'd1; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; MDUop = 3'd0;
        n = 0;
        while (busy && n < 64) begin
            n++;
            if (n == 2) begin start = 1'b1; MDUop = 3'd6; A = 32'h0000_AAAA; end
            if (n == 3) begin start = 1'b0; MDUop = 3'd0; end
            @(posedge clk); #1;
        end
        start = 1'b0; MDUop = 3'd0;
        check("mtlo in run busy cycles", n, MultN);
        check_hilo("mtlo in run", 32'd0, 32'd12);
        hi_m = 32'd0; lo_m = 32'd12;

        // Reset in the middle of a long op discards it.
        start = 1'b1; MDUop = DivEn ? 3'd3 : 3'd1; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; MDUop = 3'd0;
        repeat (3) @(posedge clk);
        #1 check("busy before reset", 32'(busy), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("busy after reset", 32'(busy), 32'd0);
        check_hilo("after reset", 32'd0, 32'd0);
        repeat (15) @(posedge clk);
        #1 check("no late busy", 32'(busy), 32'd0);
        check_hilo("no late commit", 32'd0, 32'd0);
        hi_m = '0; lo_m = '0;

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, hi_m, lo_m, eh, el, enb);
            issue($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, eh, el, enb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
